alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: MOD_WAIT, 34, cycles the ALU mod operation (op 111) needs after its mod reset pulse; legal range 1..63.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  sequencer accepts an operation this cycle.
REQ-006 in_op  input  3  ALU opcode: 000 and, 001 or, 010 xor, 011 nor, 100 less, 101 add, 110 sub, 111 mod.
REQ-007 in_a  input  32  operand A.
REQ-008 in_b  input  32  operand B.
REQ-009 alu_a  output  32  registered operand A driven to the ALU.
REQ-010 alu_b  output  32  registered operand B driven to the ALU.
REQ-011 alu_op  output  3  registered opcode driven to the ALU.
REQ-012 alu_mod_reset  output  1  reset for the ALU's sequential mod unit.
REQ-013 alu_result  input  32  ALU Result.
REQ-014 out_valid  output  1  out_result holds a completed result.
REQ-015 out_ready  input  1  downstream consumes the result.
REQ-016 out_result  output  32  captured result.
REQ-017 out_op  output  3  opcode of the captured result.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The sequencer SHALL implement states IDLE, EXEC, MODRST, WAIT, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; an operation is accepted when in_valid and in_ready are both 1.
REQ-021 On acceptance, in_a, in_b and in_op SHALL be registered into alu_a, alu_b and alu_op, which SHALL stay constant until the state returns to IDLE.
REQ-022 Accept with in_op != 111: IDLE -> EXEC; EXEC lasts one cycle; alu_result is captured into out_result at the end of EXEC; EXEC -> DONE.
REQ-023 Accept with in_op = 111: IDLE -> MODRST; alu_mod_reset = 1 for exactly that one cycle; MODRST -> WAIT.
REQ-024 WAIT SHALL last exactly MOD_WAIT cycles (6-bit down-counter loaded with MOD_WAIT-1 on entry); alu_result is captured at the end of the last WAIT cycle; WAIT -> DONE.
REQ-025 Latency, with acceptance in cycle t: non-mod out_valid first high in t+2; mod out_valid first high in t+2+MOD_WAIT.
REQ-026 In DONE, out_valid = 1; out_result and out_op SHALL hold stable until out_valid and out_ready are both 1, then DONE -> IDLE; out_valid SHALL be 0 in every other state.
REQ-027 in_valid while not in IDLE SHALL be ignored, with no effect on state or registers.
REQ-028 No accept in the DONE-exit cycle; the next accept occurs no earlier than the following cycle in IDLE.
REQ-029 ALU arithmetic is 32-bit wrap-around; the sequencer SHALL pass alu_result through unmodified.

Reset
REQ-030 While reset = 1: state SHALL go to IDLE, and alu_a, alu_b, alu_op, out_result, out_op and the counter SHALL all be 0; out_valid = 0, busy = 0, and alu_mod_reset = 1.
REQ-031 Reset in any state, including mid-WAIT, SHALL abandon the operation, and no out_valid SHALL follow for it.
REQ-032 in_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the state encoding, the eight opcode constants and the MOD_WAIT default.
REQ-034 The WAIT down-counter SHALL be a sub-module named cycle_counter, with load, decrement and zero-flag.
REQ-035 All other logic, including the FSM and the capture registers, SHALL live in alu_sequencer.

Verification
REQ-036 Add: accept op=101, A=5, B=7 in cycle t -> alu_op=101 from t+1; out_valid high in t+2 with out_result=12.
REQ-037 Sub wrap: op=110, A=3, B=5 -> out_result=0xFFFFFFFE, out_op=110.
REQ-038 Mod: op=111, A=17, B=5, MOD_WAIT=34 -> alu_mod_reset high only in t+1; out_valid high first in t+36 with out_result=2.
REQ-039 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_result held; in_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-040 Busy drop: in_valid=1 with new operands during WAIT -> ignored; the captured result matches the original operation only.
REQ-041 Reset mid-WAIT: reset=1 for 1 cycle at t+10 of a mod -> all outputs 0, no out_valid; in_ready=1 in t+11.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM state encoding,
// ALU opcode constants and the default mod wait length.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_MODRST = 3'd2,
      S_WAIT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_LESS = 3'b100;
   localparam logic [2:0] OP_ADD  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_MOD  = 3'b111;

   localparam int MOD_WAIT_DEF = 34;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with zero flag; times the mod wait.
// Ports: clk, reset, load, load_val, dec -> zero.
module cycle_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU op at a time: registers operands, waits for
// the result (multi-cycle for mod), holds it until consumed.
// Ports: in_* upstream handshake/operands, alu_* to/from ALU,
// out_* downstream handshake/result, busy status.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int MOD_WAIT = MOD_WAIT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_mod_reset,
   input  logic [31:0] alu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_op,
   output logic        busy
);

   state_t state;
   state_t next;
   logic   accept;
   logic   capture;
   logic   cnt_zero;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         S_IDLE:
            if (in_valid)
               next = (in_op == OP_MOD) ? S_MODRST : S_EXEC;
         S_EXEC:   next = S_DONE;
         S_MODRST: next = S_WAIT;
         S_WAIT:
            if (cnt_zero)
               next = S_DONE;
         S_DONE:
            if (out_ready)
               next = S_IDLE;
         default:  next = S_IDLE;
      endcase
   end

   assign accept  = (state == S_IDLE) && in_valid;
   // Result is sampled on the last cycle the ALU is given.
   assign capture = (state == S_EXEC)
                 || ((state == S_WAIT) && cnt_zero);

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         out_result <= '0;
         out_op     <= '0;
      end else begin
         if (accept) begin
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
         end
         if (capture) begin
            out_result <= alu_result;
            out_op     <= alu_op;
         end
      end
   end

   // Loaded with MOD_WAIT-1 so WAIT spans exactly MOD_WAIT cycles.
   cycle_counter #(
      .W(6)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (state == S_MODRST),
      .load_val (6'(MOD_WAIT - 1)),
      .dec      (state == S_WAIT),
      .zero     (cnt_zero)
   );

   // Reset masks the handshake outputs and holds the mod unit
   // in reset, independent of the current state register.
   assign in_ready      = (state == S_IDLE) && !reset;
   assign out_valid     = (state == S_DONE) && !reset;
   assign busy          = (state != S_IDLE) && !reset;
   assign alu_mod_reset = (state == S_MODRST) || reset;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: transaction-level model plus
// directed scenarios and randomized traffic.
module tb_alu_sequencer;

   localparam int M = 34;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic        alu_mod_reset;
   logic [31:0] alu_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_op;
   logic        busy;

   alu_sequencer #(.MOD_WAIT(M)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_a          (in_a),
      .in_b          (in_b),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_op        (alu_op),
      .alu_mod_reset (alu_mod_reset),
      .alu_result    (alu_result),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_op        (out_op),
      .busy          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_alu(
      input logic [2:0] op, input logic [31:0] a,
      input logic [31:0] b);
      case (op)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return a ^ b;
         3'b011: return ~(a | b);
         3'b100: return (a < b) ? 32'd1 : 32'd0;
         3'b101: return a + b;
         3'b110: return a - b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // ALU stand-in: mod answer only becomes correct M cycles
   // after its reset pulse ends; garbage before that.
   int mcnt = 0;
   always @(posedge clk) begin
      if (alu_mod_reset) mcnt <= 0;
      else if (mcnt < 1000) mcnt <= mcnt + 1;
   end

   always_comb begin
      alu_result = ref_alu(alu_op, alu_a, alu_b);
      if (alu_op == 3'b111 && mcnt < M - 1)
         alu_result = 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Transaction model: one pending op, done at a known cycle.
   bit          busy_m = 0;
   int          acc_cyc = 0;
   int          done_cyc = 0;
   logic [31:0] m_a = 0;
   logic [31:0] m_b = 0;
   logic [2:0]  m_op = 0;
   logic [31:0] m_res = 0;
   bit          e_valid;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_mod_reset", alu_mod_reset, 1);
         busy_m = 0;
         m_a = 0; m_b = 0; m_op = 0;
      end else begin
         e_valid = busy_m && (cyc >= done_cyc);
         chk("in_ready", in_ready, !busy_m);
         chk("out_valid", out_valid, e_valid);
         chk("busy", busy, busy_m);
         chk("mod_reset", alu_mod_reset,
             busy_m && m_op == 3'b111 && cyc == acc_cyc + 1);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_op", alu_op, m_op);
         if (e_valid) begin
            chk("out_result", out_result, m_res);
            chk("out_op", out_op, m_op);
         end
         if (!busy_m) begin
            if (in_valid) begin
               busy_m   = 1;
               acc_cyc  = cyc;
               m_a      = in_a;
               m_b      = in_b;
               m_op     = in_op;
               m_res    = ref_alu(in_op, in_a, in_b);
               done_cyc = cyc + 2 + ((in_op == 3'b111) ? M : 0);
            end
         end else if (e_valid && out_ready) begin
            busy_m = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      in_valid  = 0;
      out_ready = 1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic issue(input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = 1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
   endtask

   initial begin
      reset = 1; in_valid = 0; in_op = 0;
      in_a = 0; in_b = 0; out_ready = 1;
      repeat (3) step();
      reset = 0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_result", out_result, 0);

      // add 5+7
      wait_idle();
      issue(3'b101, 5, 7);
      step();
      in_valid = 0;
      @(negedge clk);
      chk("add_alu_op", alu_op, 3'b101);
      chk("add_early_valid", out_valid, 0);
      step();
      @(negedge clk);
      chk("add_valid", out_valid, 1);
      chk("add_result", out_result, 12);

      // sub wrap with backpressure
      wait_idle();
      out_ready = 0;
      issue(3'b110, 3, 5);
      step();
      in_valid = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_result", out_result, 32'hFFFF_FFFE);
         chk("bp_op", out_op, 3'b110);
         chk("bp_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1);
      step();
      @(negedge clk);
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_idle_valid", out_valid, 0);

      // mod 17 % 5 with ignored input during WAIT
      wait_idle();
      issue(3'b111, 17, 5);
      step();
      in_valid = 0;
      @(negedge clk);
      chk("mod_rst_pulse", alu_mod_reset, 1);
      step();
      @(negedge clk);
      chk("mod_rst_drop", alu_mod_reset, 0);
      for (int k = 3; k <= 35; k++) begin
         step();
         if (k >= 5 && k < 20) issue(3'b101, 100, 200);
         else in_valid = 0;
         if (k == 35) begin
            @(negedge clk);
            chk("mod_early_valid", out_valid, 0);
         end
      end
      step();
      @(negedge clk);
      chk("mod_valid", out_valid, 1);
      chk("mod_result", out_result, 2);
      chk("mod_alu_a_kept", alu_a, 17);
      chk("mod_out_op", out_op, 3'b111);

      // reset mid-WAIT
      wait_idle();
      issue(3'b111, 40, 7);
      for (int k = 1; k <= 10; k++) begin
         step();
         in_valid = 0;
      end
      reset = 1;
      @(negedge clk);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_mod_reset", alu_mod_reset, 1);
      chk("mrst_in_ready", in_ready, 0);
      step();
      reset = 0;
      @(negedge clk);
      chk("mrst_after_ready", in_ready, 1);
      chk("mrst_alu_a", alu_a, 0);
      chk("mrst_alu_op", alu_op, 0);
      chk("mrst_out_op", out_op, 0);
      chk("mrst_out_result", out_result, 0);
      repeat (40) step();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step();
         reset    = ($urandom_range(0, 299) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         in_op    = 3'($urandom_range(0, 7));
         if (in_op == 3'b111 && $urandom_range(0, 3) != 0)
            in_op = 3'($urandom_range(0, 6));
         in_a = $urandom;
         in_b = ($urandom_range(0, 3) == 0) ?
                32'($urandom_range(0, 9)) : $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      reset = 0;
      in_valid = 0;
      out_ready = 1;
      repeat (60) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
